// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: FSM state encoding, idle column pattern,
// row/column to hex code mapping and the single-row-low test.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } kp_state_t;

  localparam logic [3:0] COL_IDLE = 4'b1111;

  // row_oh is active-high one-hot; code = row*4 + col
  function automatic logic [3:0] key_code_f(input logic [3:0] row_oh, input logic [1:0] col);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (row_oh[i]) r = 2'(i);
    end
    return {r, col};
  endfunction

  function automatic logic one_hot_f(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Column-dwell prescaler: tick is high for one clk at the end of every SCAN_DIV-cycle dwell.
// Latency: tick is combinational from the counter; no backpressure, free-running.
module keypad_tick_gen #(
  parameter int SCAN_DIV = 66_666
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               cnt <= '0;
    else if (cnt == LAST)  cnt <= '0;
    else                   cnt <= cnt + CW'(1);
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_scan_in.sv
// 4x4 keypad scanner: one column driven low per dwell, rows debounced, accepted digits shifted into data.
// key_valid pulses one clk after the deciding tick; no backpressure. KEYPAD_REPEAT_EN enables auto-repeat.
module keypad_scan_in
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 66_666,
  parameter int DEBOUNCE_SCANS = 4
`ifdef KEYPAD_REPEAT_EN
  , parameter int REPEAT_TICKS = 60
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_n,
  output logic [3:0]  col_n,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] data
);

  localparam int MW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [MW:0] DEB_TGT = (MW+1)'(DEBOUNCE_SCANS);

  logic            tick;
  logic [3:0]      row_s1, row_s2, rows_low;
  kp_state_t       state, state_nxt;
  logic [1:0]      col_idx, col_nxt;
  logic [MW-1:0]   match, match_nxt;
  logic [MW:0]     match_inc;
  logic [3:0]      row_lat, row_nxt;
  logic            accept;
  logic [3:0]      col_n_nxt, code_nxt;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = (REPEAT_TICKS > 2) ? $clog2(REPEAT_TICKS) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);
  logic [RW-1:0] rep_cnt, rep_nxt;
`endif

  keypad_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
    end else begin
      row_s1 <= row_n;
      row_s2 <= row_s1;
    end
  end

  assign rows_low  = ~row_s2;
  assign match_inc = {1'b0, match} + (MW+1)'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SCAN;
      col_idx   <= 2'd0;
      match     <= '0;
      row_lat   <= 4'd0;
      col_n     <= 4'b1110;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      data      <= 16'd0;
    end else begin
      state     <= state_nxt;
      col_idx   <= col_nxt;
      match     <= match_nxt;
      row_lat   <= row_nxt;
      col_n     <= col_n_nxt;
      key_valid <= accept;
      if (accept) begin
        key_code <= code_nxt;
        data     <= {data[11:0], code_nxt};
      end
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rep_cnt <= '0;
    else     rep_cnt <= rep_nxt;
  end
`endif

  always_comb begin
    state_nxt = state;
    col_nxt   = col_idx;
    match_nxt = match;
    row_nxt   = row_lat;
    accept    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    rep_nxt   = rep_cnt;
`endif
    if (tick) begin
      unique case (state)
        SCAN: begin
          // zero or several rows low: nothing trustworthy on this column
          if (one_hot_f(rows_low)) begin
            row_nxt   = rows_low;
            match_nxt = MW'(1);
            if (DEBOUNCE_SCANS == 1) begin
              accept    = 1'b1;
              state_nxt = HELD;
            end else begin
              state_nxt = DEBOUNCE;
            end
          end else begin
            col_nxt = col_idx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (rows_low == row_lat) begin
            match_nxt = match_inc[MW-1:0];
            if (match_inc == DEB_TGT) begin
              accept    = 1'b1;
              state_nxt = HELD;
            end
          end else begin
            match_nxt = '0;
            col_nxt   = col_idx + 2'd1;
            state_nxt = SCAN;
          end
        end
        HELD: begin
          if (rows_low == 4'd0) begin
            if (DEBOUNCE_SCANS == 1) begin
              match_nxt = '0;
              col_nxt   = col_idx + 2'd1;
              state_nxt = SCAN;
            end else begin
              match_nxt = MW'(1);
              state_nxt = RELEASE;
            end
          end
`ifdef KEYPAD_REPEAT_EN
          else if (rep_cnt == REP_LAST) begin
            accept  = 1'b1;
            rep_nxt = '0;
          end else begin
            rep_nxt = rep_cnt + RW'(1);
          end
`else
          // key (or a second key) still down: wait for full release
`endif
        end
        RELEASE: begin
          if (rows_low == 4'd0) begin
            match_nxt = match_inc[MW-1:0];
            if (match_inc == DEB_TGT) begin
              match_nxt = '0;
              col_nxt   = col_idx + 2'd1;
              state_nxt = SCAN;
            end
          end else begin
            match_nxt = '0;
            state_nxt = HELD;
          end
        end
        default: state_nxt = SCAN;
      endcase
    end
`ifdef KEYPAD_REPEAT_EN
    if (state_nxt != HELD) rep_nxt = '0;
`endif
  end

  always_comb begin
    col_n_nxt = COL_IDLE ^ (4'b0001 << col_nxt);
    code_nxt  = key_code_f(row_nxt, col_idx);
  end

endmodule

// File: tb/tb_keypad_scan_in.sv
// Scoreboard bench for keypad_scan_in: a keypad model drives rows from col_n, stimulus pushes expected accepts.
module tb_keypad_scan_in;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
`ifdef KEYPAD_REPEAT_EN
  localparam int REP      = 3;
  localparam bit REP_ON   = 1'b1;
`else
  localparam bit REP_ON   = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] data;

  logic [15:0] pressed = 16'd0;
  logic [15:0] exp_data = 16'd0;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct packed {
    logic [3:0]  code;
    logic [15:0] dat;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  keypad_scan_in #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB)
`ifdef KEYPAD_REPEAT_EN
    , .REPEAT_TICKS (REP)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row_n     (row_n),
    .col_n     (col_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .data      (data)
  );

  // Matrix model: a pressed key pulls its row low while its column is driven low
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[4*r+c] && !col_n[c]) row_n[r] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] col_pat(input int col);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << col);
  endfunction

  // Returns just after col_n switches onto the column, i.e. at the start of its dwell
  task automatic align(input int col);
    int k;
    k = 0;
    while (col_n == col_pat(col) && k < 40) begin clocks(1); k++; end
    while (col_n != col_pat(col) && k < 40) begin clocks(1); k++; end
    check("align_col", col_n, col_pat(col));
  endtask

  task automatic press(input int code, input int nticks, input int nacc, input int settle);
    int col;
    col = code % 4;
    for (int i = 0; i < nacc; i++) begin
      exp_data = {exp_data[11:0], 4'(code)};
      sb_q.push_back({4'(code), exp_data});
    end
    align(col);
    pressed[code] = 1'b1;
    clocks(4 * nticks);
    check("col_frozen", col_n, col_pat(col));
    pressed = 16'd0;
    clocks(settle);
    check("col_resume", col_n, col_pat((col + 1) % 4));
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (key_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pulse: key_valid=1 key_code=0x%0h data=0x%0h, no accept expected",
                   key_code, data);
        end else begin
          e = sb_q.pop_front();
          check("sb_key_code", key_code, e.code);
          check("sb_data", data, e.dat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] idle_seq [4];
    idle_seq[0] = 4'b1101; idle_seq[1] = 4'b1011; idle_seq[2] = 4'b0111; idle_seq[3] = 4'b1110;

    rst = 1'b1;
    clocks(3);
    check("rst_col_n", col_n, 4'b1110);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_key_code", key_code, 4'h0);
    check("rst_data", data, 16'h0000);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      clocks(4);
      check("idle_scan", col_n, idle_seq[i]);
    end

    // row1/col2 held 10 ticks
    press(6, 10, REP_ON ? 3 : 1, 8);
    check("key6_code", key_code, 4'h6);
    check("key6_data", data, REP_ON ? 16'h0666 : 16'h0006);

    // five digits, oldest dropped
    for (int d = 1; d <= 5; d++) press(d, 2, 1, 8);
    check("seq_data", data, 16'h2345);
    check("seq_code", key_code, 4'h5);

    // one-tick bounce on key 0xA
    press(10, 1, 0, 4);
    check("bounce_data", data, 16'h2345);
    check("bounce_code", key_code, 4'h5);

    // rows 0 and 2 low together on col1
    align(1);
    pressed[1] = 1'b1;
    pressed[9] = 1'b1;
    clocks(4);
    check("multi_col_adv", col_n, 4'b1011);
    pressed = 16'd0;
    clocks(8);
    check("multi_data", data, 16'h2345);

    // reset during debounce
    align(1);
    pressed[5] = 1'b1;
    clocks(4);
    check("deb_col_frozen", col_n, 4'b1101);
    rst = 1'b1;
    #1;
    check("mid_rst_col_n", col_n, 4'b1110);
    check("mid_rst_data", data, 16'h0000);
    clocks(2);
    pressed = 16'd0;
    exp_data = 16'd0;
    rst = 1'b0;
    clocks(16);
    check("post_rst_data", data, 16'h0000);
    check("post_rst_valid", key_valid, 1'b0);

    // hold key 0xF for 12 ticks
    press(15, 12, REP_ON ? 4 : 1, 8);
    check("keyF_data", data, REP_ON ? 16'hFFFF : 16'h000F);
    check("keyF_code", key_code, 4'hF);

    clocks(8);
    check("sb_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
